// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side load/store initiator for a word-wide data memory
// that has a registered address port and no byte enables. Sub-word loads are
// lane-selected and extended. Sub-word stores use read-modify-write.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word requests are reported through resp_err_o. When it is not defined,
// the low address bits are forced to alignment.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_MERGE, S_RESP} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              off_q, off_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;

  logic [1:0]              sz_in;
  logic [1:0]              off_in;
  logic                    misal;
  logic [7:0]              lane_b;
  logic [15:0]             lane_h;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   merged;

  // Size 3 behaves as a word. Offsets are forced to the natural alignment.
  assign sz_in = (req_size_i == 2'd3) ? SZ_W : req_size_i;

  // Pick the byte offset that the access actually uses.
  always_comb begin
    off_in = 2'b00;
    case (sz_in)
      SZ_B:    off_in = req_addr_i[1:0];
      SZ_H:    off_in = {req_addr_i[1], 1'b0};
      default: off_in = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misal = ((sz_in == SZ_H) && req_addr_i[0]) ||
                 ((sz_in == SZ_W) && (req_addr_i[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign lane_b = mem_rdata_i[{off_q, 3'b000} +: 8];
  assign lane_h = mem_rdata_i[{off_q[1], 4'b0000} +: 16];

  // Extend the selected load lane to a full word.
  always_comb begin
    load_ext = mem_rdata_i;
    case (size_q)
      SZ_B:    load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      SZ_H:    load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // Overlay the store lane(s) onto the word that was just read.
  always_comb begin
    merged = mem_rdata_i;
    if (size_q == SZ_B)      merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
    else if (size_q == SZ_H) merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        we_d         = req_we_i;
        size_d       = sz_in;
        uns_d        = req_unsigned_i;
        off_d        = off_in;
        wdata_d      = req_wdata_i[15:0];
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        if (misal) begin
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          mem_addr_d = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          if (req_we_i && (sz_in == SZ_W)) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata_i;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          state_d = S_CAPTURE;
        end else if (size_q == SZ_W) begin
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          // The write pulse lines up with the cycle in which read data is valid.
          mem_we_d = 1'b1;
          state_d  = S_MERGE;
        end
      end
      S_CAPTURE: begin
        resp_rdata_d = load_ext;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_MERGE: begin
        mem_wdata_d  = merged;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. Reset drops any request that is in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  // Merge data comes from mem_rdata in the same cycle that memory samples the
  // write, so it bypasses the register only while in MERGE.
  assign mem_wdata_o  = (state_q == S_MERGE) ? merged : mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: bench for load_store_unit. It contains a registered-
// address memory model, a directed vector table, corner-case sequences, and
// random traffic that is checked against a byte-addressed reference memory.
// It follows MISALIGN_TRAP_EN in the same way as the design.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: 64 words. The address is sampled at the edge, read data is
  // valid the next cycle, and a write commits one edge after it is sampled.
  logic [31:0] mem [64];
  logic [5:0]  ra_q, wa_q;
  logic        wp_q;
  logic [31:0] wd_q;
  logic        mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      wp_q <= 1'b0;
    end else begin
      if (wp_q) mem[wa_q] <= wd_q;
      wp_q <= mem_we;
    end
    wa_q <= mem_addr[7:2];
    wd_q <= mem_wdata;
    ra_q <= mem_addr[7:2];
  end
  assign mem_rdata = mem[ra_q];

  // Reference model: a little-endian byte array.
  logic [7:0] ref_b [256];

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_misal(logic [1:0] sz, logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (nbytes(sz) > 1) && ((a % nbytes(sz)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_ld(logic [1:0] sz, logic uns, logic [31:0] a);
    int n = nbytes(sz);
    int base = int'(a % 256) - int'(a % 256) % n;
    logic [31:0] v = '0;
    logic [31:0] one = 32'd1;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[base + i]) << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((one << (8 * n)) - 1);
    return v;
  endfunction

  task automatic ref_st(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
    int n = nbytes(sz);
    int base = int'(a % 256) - int'(a % 256) % n;
    for (int i = 0; i < n; i++) ref_b[base + i] = 8'(wd >> (8 * i));
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request. The call starts and ends at a negedge. lat counts the
  // cycles from the accept edge to resp_valid, and wes counts mem_we cycles.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int wes);
    int g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    lat = 1; wes = 0;
    while (1) begin
      wes += int'(mem_we);
      if (resp_valid) break;
      if (lat >= 20) begin lat = -1; break; end
      @(negedge clk); lat++;
    end
    rd = resp_rdata; er = resp_err;
  endtask

  task automatic run_op(string nm, logic we, logic [1:0] sz, logic uns,
                        logic [31:0] a, logic [31:0] wd);
    logic [31:0] rd, erd; logic er, eer; int lat, wes, elat, ewes;
    eer  = ref_misal(sz, a);
    erd  = (eer || we) ? 32'd0 : ref_ld(sz, uns, a);
    elat = eer ? 1 : (we && nbytes(sz) == 4) ? 2 : 3;
    ewes = (we && !eer) ? 1 : 0;
    do_req(we, sz, uns, a, wd, rd, er, lat, wes);
    if (we && !eer) ref_st(sz, a, wd);
    chk({nm, ".rdata"}, rd, erd);
    chk({nm, ".err"}, 32'(er), 32'(eer));
    chk({nm, ".lat"}, lat, elat);
    chk({nm, ".we_pulses"}, wes, ewes);
  endtask

  typedef struct {
    logic we; logic [1:0] sz; logic uns; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] rdata; logic err; int lat; int wes;
  } vec_t;
  vec_t vt [13];

  initial begin
    logic [31:0] rd; logic er; int lat, wes, acc, rsp, both;
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
    vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
    vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'h0,        1'b0, 2, 1};
    vt[3]  = '{1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 32'h0,        1'b0, 3, 1};
    vt[4]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h1122AA44, 1'b0, 3, 0};
    vt[5]  = '{1'b0, 2'd0, 1'b0, 32'h21, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 0};
    vt[6]  = '{1'b0, 2'd0, 1'b1, 32'h21, 32'h0,        32'h000000AA, 1'b0, 3, 0};
    vt[7]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h12348001, 32'h0,        1'b0, 3, 1};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h8001AA44, 1'b0, 3, 0};
    vt[9]  = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 3, 0};
    vt[11] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
`ifdef MISALIGN_TRAP_EN
    vt[10] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0};
    vt[12] = '{1'b0, 2'd1, 1'b1, 32'h23, 32'h0,        32'h0,        1'b1, 1, 0};
`else
    vt[10] = '{1'b0, 2'd2, 1'b0, 32'h13, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
    vt[12] = '{1'b0, 2'd1, 1'b1, 32'h23, 32'h0,        32'h00008001, 1'b0, 3, 0};
`endif

    // Check the reset state while rst is still held.
    @(negedge clk); @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.resp_rdata", resp_rdata, 0);
    chk("rst.resp_err", 32'(resp_err), 0);
    mem_clr = 1'b0; rst = 1'b0;
    @(negedge clk);

    // Directed vector table.
    foreach (vt[i]) begin
      do_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat, wes);
      if (vt[i].we && !vt[i].err) ref_st(vt[i].sz, vt[i].addr, vt[i].wdata);
      chk($sformatf("vec%0d.rdata", i), rd, vt[i].rdata);
      chk($sformatf("vec%0d.err", i), 32'(er), 32'(vt[i].err));
      chk($sformatf("vec%0d.lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d.we_pulses", i), wes, vt[i].wes);
    end

    // Reset during MERGE: the write is abandoned and no response is given.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h41; req_wdata = 32'h5A;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("merge.mem_we_before_rst", 32'(mem_we), 1);
    rst = 1'b1; #1;
    chk("merge_rst.mem_we", 32'(mem_we), 0);
    chk("merge_rst.req_ready", 32'(req_ready), 0);
    chk("merge_rst.resp_valid", 32'(resp_valid), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("merge_rst.ready_after", 32'(req_ready), 1);
    rsp = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); rsp += int'(resp_valid); end
    chk("merge_rst.no_resp", rsp, 0);
    run_op("merge_rst.reload", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

    // Hold req_valid high: each accept gets exactly one response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20;
    acc = 0; rsp = 0; both = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i < 31 && req_ready) acc++;
      if (req_ready && resp_valid) both++;
      if (resp_valid) begin
        rsp++;
        chk("held.rdata", resp_rdata, ref_ld(2'd2, 1'b0, 32'h20));
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) rsp++;
    end
    chk("held.accepts", acc, 8);
    chk("held.responses", rsp, acc);
    chk("held.ready_in_resp", both, 0);

    // Random traffic checked against the byte model.
    for (int i = 0; i < 150; i++)
      run_op($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom_range(0, 255)) | ($urandom & 32'hFFFF_FF00), $urandom);

    // Compare the final memory image with the model.
    repeat (4) @(negedge clk);
    for (int w = 0; w < 64; w++)
      chk($sformatf("image.w%0d", w), mem[w],
          {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
